// File: rtl/muldiv_pkg.sv
// Shared constants, operation codes and state encoding for the multiply/divide unit.
package muldiv_pkg;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned ITER  = 32;
    localparam int unsigned CNT_W = $clog2(ITER) + 1;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Radix-2 iteration datapath: 64-bit accumulator plus a 33-bit add/subtract.
// Multiply: acc = {partial, multiplier}; shift-add, product ends in acc.
// Divide:   acc = {remainder, dividend/quotient}; restoring shift-subtract.
module muldiv_iter
    import muldiv_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 init,
    input  logic                 step,
    input  logic                 is_div,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    output logic [2*WIDTH-1:0]   acc_nxt_c
);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH:0]     sum_c;

    // Next accumulator: load operands on init, otherwise one step per enable
    always_comb begin
        acc_d = acc_q;
        b_d   = b_q;
        sum_c = '0;
        if (init) begin
            acc_d = {WIDTH'(0), a_in};
            b_d   = b_in;
        end else if (step) begin
            if (is_div) begin
                // borrow in bit WIDTH means the shifted remainder was below the divisor
                sum_c = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
                if (!sum_c[WIDTH]) begin
                    acc_d = {sum_c[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                end
            end else begin
                sum_c = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : (WIDTH+1)'(0));
                acc_d = {sum_c, acc_q[WIDTH-1:1]};
            end
        end
    end

    assign acc_nxt_c = acc_d;

    // Accumulator and held divisor/multiplicand registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            b_q   <= b_d;
        end
    end

endmodule

// File: rtl/muldiv32.sv
// Multiply/divide unit with HI/LO registers: control FSM, sign handling, result registers.
module muldiv32
    import muldiv_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;
    logic               is_div_q, is_div_d, neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;

    md_op_e             op_c;
    logic               sgn_c, div_op_c, a_neg_c, b_neg_c;
    logic [WIDTH-1:0]   a_mag_c, b_mag_c;
    logic               iter_init_c, iter_step_c;
    logic [2*WIDTH-1:0] acc_nxt_c, prod_c;

    // Operand decode and magnitudes for the signed variants
    always_comb begin
        op_c     = md_op_e'(op);
        sgn_c    = (op_c == MD_MULT) || (op_c == MD_DIV);
        div_op_c = (op_c == MD_DIV) || (op_c == MD_DIVU);
        a_neg_c  = sgn_c & read_data_1[WIDTH-1];
        b_neg_c  = sgn_c & read_data_2[WIDTH-1];
        a_mag_c  = a_neg_c ? -read_data_1 : read_data_1;
        b_mag_c  = b_neg_c ? -read_data_2 : read_data_2;
    end

    muldiv_iter u_iter (
        .clock     (clock),
        .reset     (reset),
        .init      (iter_init_c),
        .step      (iter_step_c),
        .is_div    (is_div_q),
        .a_in      (a_mag_c),
        .b_in      (b_mag_c),
        .acc_nxt_c (acc_nxt_c)
    );

    // Next-state, HI/LO update and status flags
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        dbz_d       = 1'b0;
        is_div_d    = is_div_q;
        neg_res_d   = neg_res_q;
        neg_rem_d   = neg_rem_q;
        iter_init_c = 1'b0;
        iter_step_c = 1'b0;
        prod_c      = '0;
        case (state_q)
            IDLE, FINISH: begin
                state_d = IDLE;
                if (start) begin
                    case (op_c)
                        MD_MTHI: hi_d = read_data_1;
                        MD_MTLO: lo_d = read_data_1;
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            if (div_op_c && (read_data_2 == '0)) begin
                                done_d = 1'b1;
                                dbz_d  = 1'b1;
                            end else begin
                                iter_init_c = 1'b1;
                                is_div_d    = div_op_c;
                                neg_res_d   = a_neg_c ^ b_neg_c;
                                neg_rem_d   = a_neg_c;
                                cnt_d       = '0;
                                busy_d      = 1'b1;
                                state_d     = RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            RUN: begin
                iter_step_c = 1'b1;
                cnt_d       = CNT_W'(cnt_q + 1'b1);
                if (cnt_q == CNT_W'(ITER - 1)) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FINISH;
                    if (is_div_q) begin
                        lo_d = neg_res_q ? -acc_nxt_c[WIDTH-1:0] : acc_nxt_c[WIDTH-1:0];
                        hi_d = neg_rem_q ? -acc_nxt_c[2*WIDTH-1:WIDTH] : acc_nxt_c[2*WIDTH-1:WIDTH];
                    end else begin
                        prod_c = neg_res_q ? -acc_nxt_c : acc_nxt_c;
                        hi_d   = prod_c[2*WIDTH-1:WIDTH];
                        lo_d   = prod_c[WIDTH-1:0];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and result registers
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dbz_q     <= 1'b0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            dbz_q     <= dbz_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dbz_q;
    assign hi_out      = hi_q;
    assign lo_out      = lo_q;

endmodule

// File: tb/tb_muldiv32.sv
// Self-checking bench for muldiv32 against a 64-bit arithmetic reference model.
module tb_muldiv32;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] read_data_1;
    logic [31:0] read_data_2;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int checks;
    int failures;

    muldiv32 dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .read_data_1 (read_data_1),
        .read_data_2 (read_data_2),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi_out      (hi_out),
        .lo_out      (lo_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Reference: full-width arithmetic; SV / truncates toward zero, % takes dividend sign
    function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        longint          sa, sb, sp, sq, sr;
        longint unsigned ua, ub, up, uq, ur;
        sa = longint'(int'(a));
        sb = longint'(int'(b));
        ua = {32'h0, a};
        ub = {32'h0, b};
        eh = 32'h0;
        el = 32'h0;
        case (o)
            3'd0: begin sp = sa * sb; eh = sp[63:32]; el = sp[31:0]; end
            3'd1: begin up = ua * ub; eh = up[63:32]; el = up[31:0]; end
            3'd2: begin sq = sa / sb; sr = sa % sb; el = sq[31:0]; eh = sr[31:0]; end
            3'd3: begin uq = ua / ub; ur = ua % ub; el = uq[31:0]; eh = ur[31:0]; end
            default: ;
        endcase
    endfunction

    // Issue an iterative op at a negedge; returns at the negedge where done should be high
    task automatic do_iter(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] eh, el;
        int n;
        model(o, a, b, eh, el);
        start = 1'b1; op = o; read_data_1 = a; read_data_2 = b;
        @(negedge clock);
        start = 1'b0;
        n = 0;
        while (busy === 1'b1 && n < 40) begin
            read_data_1 = $urandom;
            read_data_2 = $urandom;
            n++;
            @(negedge clock);
        end
        checks++;
        if (n !== 32) begin failures++; $display("FAIL %s busy_cycles: got %0d expected 32", name, n); end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL %s done: got %b expected 1", name, done); end
        checks++;
        if (div_by_zero !== 1'b0) begin failures++; $display("FAIL %s dbz: got %b expected 0", name, div_by_zero); end
        checks++;
        if (hi_out !== eh) begin failures++; $display("FAIL %s hi: got %h expected %h", name, hi_out, eh); end
        checks++;
        if (lo_out !== el) begin failures++; $display("FAIL %s lo: got %h expected %h", name, lo_out, el); end
    endtask

    task automatic idle_check(input string name);
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++; $display("FAIL %s idle: got done=%b busy=%b expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; start = 1'b0; op = 3'd0; read_data_1 = 32'h0; read_data_2 = 32'h0;
        repeat (2) @(negedge clock);
        reset = 1'b1;
        checks++;
        if (hi_out !== 32'h0 || lo_out !== 32'h0) begin
            failures++; $display("FAIL reset_hilo: got %h/%h expected 0/0", hi_out, lo_out);
        end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
            failures++; $display("FAIL reset_flags: got busy=%b done=%b dbz=%b expected 0", busy, done, div_by_zero);
        end
    endtask

    task automatic test_moves();
        start = 1'b1; op = 3'd4; read_data_1 = 32'h12345678;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (hi_out !== 32'h12345678) begin failures++; $display("FAIL mthi: got %h expected 12345678", hi_out); end
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL mthi_flags: got busy=%b done=%b expected 0 0", busy, done); end
        start = 1'b1; op = 3'd5; read_data_1 = 32'hCAFEF00D;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (lo_out !== 32'hCAFEF00D || hi_out !== 32'h12345678) begin
            failures++; $display("FAIL mtlo: got %h/%h expected 12345678/cafef00d", hi_out, lo_out);
        end
        // op 6 and 7 leave everything untouched
        start = 1'b1; op = 3'd6; read_data_1 = 32'h0;
        @(negedge clock);
        op = 3'd7;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (lo_out !== 32'hCAFEF00D || hi_out !== 32'h12345678 || busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL noop: got hi=%h lo=%h busy=%b done=%b", hi_out, lo_out, busy, done);
        end
    endtask

    task automatic test_directed();
        do_iter(3'd0, 32'h80000000, 32'h80000000, "mult_min");   idle_check("mult_min");
        do_iter(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, "multu_max");  idle_check("multu_max");
        do_iter(3'd2, 32'hFFFFFFF9, 32'h00000002, "div_neg");    idle_check("div_neg");
        do_iter(3'd3, 32'hFFFFFFF9, 32'h00000002, "divu");       idle_check("divu");
        do_iter(3'd2, 32'h80000000, 32'hFFFFFFFF, "div_ovf");    idle_check("div_ovf");
        do_iter(3'd2, 32'h00000007, 32'hFFFFFFFE, "div_negd");   idle_check("div_negd");
        do_iter(3'd0, 32'hFFFFFFFD, 32'h00000005, "mult_neg");   idle_check("mult_neg");
    endtask

    task automatic test_div_by_zero();
        logic [31:0] old_lo;
        start = 1'b1; op = 3'd4; read_data_1 = 32'hAAAA0000;
        @(negedge clock);
        old_lo = lo_out;
        op = 3'd2; read_data_1 = 32'h1234; read_data_2 = 32'h0;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || div_by_zero !== 1'b1) begin
            failures++; $display("FAIL dbz_flags: got done=%b dbz=%b expected 1 1", done, div_by_zero);
        end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL dbz_busy: got %b expected 0", busy); end
        checks++;
        if (hi_out !== 32'hAAAA0000 || lo_out !== old_lo) begin
            failures++; $display("FAIL dbz_hilo: got %h/%h expected aaaa0000/%h", hi_out, lo_out, old_lo);
        end
        @(negedge clock);
        checks++;
        if (done !== 1'b0 || div_by_zero !== 1'b0) begin
            failures++; $display("FAIL dbz_pulse: got done=%b dbz=%b expected 0 0", done, div_by_zero);
        end
    endtask

    task automatic test_busy_ignore();
        logic [31:0] old_lo, eh, el;
        int n;
        old_lo = lo_out;
        model(3'd3, 32'd1000, 32'd7, eh, el);
        start = 1'b1; op = 3'd3; read_data_1 = 32'd1000; read_data_2 = 32'd7;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        start = 1'b1; op = 3'd5; read_data_1 = 32'd5;
        @(negedge clock);
        start = 1'b0;
        checks++;
        if (lo_out !== old_lo) begin failures++; $display("FAIL busy_mtlo: got %h expected %h", lo_out, old_lo); end
        n = 0;
        while (busy === 1'b1 && n < 40) begin n++; @(negedge clock); end
        checks++;
        if (done !== 1'b1 || lo_out !== el || hi_out !== eh) begin
            failures++; $display("FAIL busy_result: got done=%b hi=%h lo=%h expected 1 %h %h", done, hi_out, lo_out, eh, el);
        end
        idle_check("busy_ignore");
    endtask

    task automatic test_reset_mid();
        start = 1'b1; op = 3'd1; read_data_1 = 32'h0000FFFF; read_data_2 = 32'h00010001;
        @(negedge clock);
        start = 1'b0;
        repeat (9) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || hi_out !== 32'h0 || lo_out !== 32'h0) begin
            failures++; $display("FAIL reset_mid: got busy=%b done=%b hi=%h lo=%h expected 0", busy, done, hi_out, lo_out);
        end
        repeat (30) begin
            @(negedge clock);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++; $display("FAIL reset_mid_nodone: got done=%b busy=%b expected 0 0", done, busy);
            end
        end
    endtask

    task automatic test_back_to_back();
        do_iter(3'd0, 32'h00001234, 32'hFFFF0000, "b2b_first");
        do_iter(3'd3, 32'hDEADBEEF, 32'h00000013, "b2b_second");
        do_iter(3'd2, 32'h7FFFFFFF, 32'h80000000, "b2b_third");
        idle_check("b2b");
    endtask

    task automatic test_random();
        logic [2:0]  o;
        logic [31:0] a, b;
        for (int i = 0; i < 24; i++) begin
            o = 3'($urandom_range(0, 3));
            a = $urandom;
            b = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 300)) : $urandom;
            if (b == 32'h0) b = 32'h1;
            if (i % 5 == 0) a = 32'($urandom_range(0, 100));
            do_iter(o, a, b, "random");
            idle_check("random");
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_moves();
        test_directed();
        test_div_by_zero();
        test_busy_ignore();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/muldiv32.md
Name: muldiv32

Overview:
- Multiply/divide unit with the HI/LO register pair, in the execute stage directly downstream of the register-file/decode stage.
- Consumes rs/rt operands (read_data_1, read_data_2) and implements the iterative operations mult, multu, div and divu.
- Also implements the single-cycle moves mthi and mtlo.
- Exposes HI/LO for mfhi/mflo write-back through the decode stage's ALU_result path.
- Asserts busy so the controller stalls the pipeline during iteration.

Parameters:
- WIDTH, 32, operand width. Only 32 is supported; the parameter exists for the package constants.
- ITER, 32, number of iteration cycles per mult/div.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; reset==0 at a rising edge resets the block.
- start  in  1  request, qualified by op; accepted only when busy==0.
- op  in  3  operation: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; values 6 and 7 are no-ops.
- read_data_1  in  32  rs operand: multiplicand or dividend; source for mthi/mtlo.
- read_data_2  in  32  rt operand: multiplier or divisor.
- busy  out  1  high while an iterative operation is in progress.
- done  out  1  one-cycle pulse when HI/LO are updated by mult/div, or on divide-by-zero.
- div_by_zero  out  1  valid with done; high when a div/divu had a zero divisor.
- hi_out  out  32  current HI.
- lo_out  out  32  current LO.

Behaviour:
- Reset values: HI=0, LO=0, busy=0, done=0, div_by_zero=0. The state machine goes to IDLE and the counter to 0.
- Reset mid-operation aborts the operation; no HI/LO update and no done pulse.
- States: IDLE, RUN, FINISH.
- IDLE, start=1, op=MTHI at edge E0: HI<=read_data_1. No busy, no done.
- IDLE, start=1, op=MTLO at edge E0: LO<=read_data_1. No busy, no done.
- IDLE, start=1, op in MULT..DIVU with nonzero divisor (or any mult) at E0:
  - Latch operand magnitudes; for signed ops take two's-complement absolute values.
  - Latch result sign: mult uses a^b sign; div uses quotient sign a^b and remainder sign a.
  - Clear the 64-bit accumulator, set counter=0, busy<=1, go to RUN.
- IDLE, start=1, op=DIV/DIVU with read_data_2==0 at E0:
  - HI/LO unchanged, busy stays 0.
  - done<=1 and div_by_zero<=1 for exactly the cycle after E0.
- RUN: one radix-2 step per edge, E1..E(ITER).
  - Multiply: shift-add into the 64-bit product.
  - Divide: restoring shift-subtract, giving a 32-bit quotient and remainder.
  - Counter increments each step. The step at E(ITER) is the last; at that same edge:
    - Sign-correct the result (negate where the sign is set).
    - Multiply: HI<=product[63:32], LO<=product[31:0].
    - Divide: LO<=quotient, HI<=remainder.
    - busy<=0, done<=1, div_by_zero<=0, go to FINISH.
- Timing: busy is visible high for exactly ITER cycles after E0.
- FINISH lasts one cycle: done<=0, go to IDLE. A start during FINISH is accepted, like IDLE.
- Divide semantics: quotient truncates toward zero; remainder takes the dividend's sign.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Operands are latched at E0. Changes to read_data_1/read_data_2 during RUN have no effect.
- start while busy==1 is ignored, including MTHI/MTLO; the controller must stall.
- start with op 6/7 is a no-op.
- hi_out/lo_out are direct register outputs. A mfhi/mflo in the cycle after E(ITER) sees the new values.

Decomposition:
- Package muldiv_pkg holds:
  - op encodings MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO;
  - state encodings IDLE/RUN/FINISH;
  - constants WIDTH=32 and ITER=32.
- One natural sub-module, muldiv_iter: the 64-bit accumulator plus a 33-bit add/subtract datapath performing one multiply or divide step per enable.
- The top level keeps the state machine, sign handling and HI/LO registers.

Test Plan:
- Reset and mthi: reset=0 for 2 cycles -> HI=LO=0, busy=0, done=0. Then MTHI with rs=0x12345678 -> HI=0x12345678 next cycle, busy never high.
- MULT, signed minimum: rs=0x80000000, rt=0x80000000 -> busy high 32 cycles, then done pulse, HI=0x40000000, LO=0x00000000.
- MULTU: rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV signed: rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU: rs=0xFFFFFFF9, rt=2 -> LO=0x7FFFFFFC, HI=1.
- DIV overflow: 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: DIV with HI=0xAAAA0000 preloaded and rt=0 -> done=1 and div_by_zero=1 the next cycle, busy stays 0, HI/LO unchanged.
- Busy and reset interactions:
  - start MTLO with rs=5 during RUN -> ignored, LO keeps its old value until the done-cycle update.
  - reset=0 at iteration 10 -> busy=0, HI=LO=0, no done.
  - Back-to-back: start asserted during the FINISH cycle -> accepted, busy high for the next 32 cycles.
